// File: rtl/pcieifc_sram_rd_streamer_if.sv
// rtl/pcieifc_sram_rd_streamer_if.sv - command, SRAM read port and output stream bundle for the SRAM read streamer
interface pcieifc_sram_rd_streamer_if #(
  parameter int DATAWIDTH = 256,
  parameter int ADDRWIDTH = 9
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [ADDRWIDTH:0]   cmd_len;
  logic                 sram_reb;
  logic [ADDRWIDTH-1:0] sram_addrb;
  logic [DATAWIDTH-1:0] sram_doutb;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, sram_doutb, out_ready,
    output cmd_ready, sram_reb, sram_addrb, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, sram_doutb, out_ready,
    input  cmd_ready, sram_reb, sram_addrb, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pcieifc_sram_rd_streamer.sv
// rtl/pcieifc_sram_rd_streamer.sv - SRAM read engine turning (addr, len) commands into a last-tagged stream
// Optional statistics counters are enabled with PCIEI_RDSTRM_STAT_EN.
module pcieifc_sram_rd_streamer #(
  parameter int DATAWIDTH = 256,
  parameter int ADDRWIDTH = 9
) (
  input  logic clk,
  input  logic rst,
  pcieifc_sram_rd_streamer_if.master bus
`ifdef PCIEI_RDSTRM_STAT_EN
  ,
  output logic [15:0] stat_cmd_cnt,
  output logic [31:0] stat_word_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRWIDTH:0]   rd_rem_q, rd_rem_d;
  logic                 inflight_q, inflight_d;
  logic                 infl_last_q, infl_last_d;
  logic [1:0]           occ_q, occ_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [DATAWIDTH-1:0] buf_data_q [2];
  logic [DATAWIDTH-1:0] buf_data_d [2];
  logic [1:0]           buf_last_q, buf_last_d;

  logic       cmd_hs;
  logic       pop;
  logic       push;
  logic       issue;
  logic       rem_is_one;
  logic [2:0] pending;

  always_comb begin
    cmd_hs     = bus.cmd_valid && (state_q == S_IDLE);
    pop        = (occ_q != 2'd0) && bus.out_ready;
    push       = inflight_q;
    rem_is_one = (rd_rem_q == {{ADDRWIDTH{1'b0}}, 1'b1});
    pending    = {1'b0, occ_q} + {2'b00, inflight_q};
    // A pop this cycle frees a slot, so issue may proceed even with the buffer full.
    issue      = (state_q == S_RUN) && (pending < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_rem_d    = rd_rem_q;
    inflight_d  = issue;
    infl_last_d = issue && rem_is_one;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;

    if (push) begin
      buf_data_d[wr_ptr_q] = bus.sram_doutb;
      buf_last_d[wr_ptr_q] = infl_last_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_hs && (bus.cmd_len != '0)) begin
          rd_addr_d = bus.cmd_addr;
          rd_rem_d  = bus.cmd_len;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + 1'b1;
          rd_rem_d  = rd_rem_q - 1'b1;
          if (rem_is_one) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((occ_d == 2'd0) && !inflight_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      rd_rem_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf_data_q  <= '{default: '0};
      buf_last_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_rem_q    <= rd_rem_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE) && !rst;
  assign bus.sram_reb   = issue && !rst;
  assign bus.sram_addrb = rd_addr_q;
  assign bus.out_valid  = (occ_q != 2'd0) && !rst;
  assign bus.out_data   = buf_data_q[rd_ptr_q];
  assign bus.out_last   = buf_last_q[rd_ptr_q] && bus.out_valid;

`ifdef PCIEI_RDSTRM_STAT_EN
  logic [15:0] stat_cmd_cnt_q, stat_cmd_cnt_d;
  logic [31:0] stat_word_cnt_q, stat_word_cnt_d;

  always_comb begin
    stat_cmd_cnt_d  = stat_cmd_cnt_q;
    stat_word_cnt_d = stat_word_cnt_q;
    if (cmd_hs && (bus.cmd_len != '0)) begin
      stat_cmd_cnt_d = stat_cmd_cnt_q + 16'd1;
    end
    if (pop) begin
      stat_word_cnt_d = stat_word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cmd_cnt_q  <= 16'd0;
      stat_word_cnt_q <= 32'd0;
    end else begin
      stat_cmd_cnt_q  <= stat_cmd_cnt_d;
      stat_word_cnt_q <= stat_word_cnt_d;
    end
  end

  assign stat_cmd_cnt  = stat_cmd_cnt_q;
  assign stat_word_cnt = stat_word_cnt_q;
`else
  // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_pcieifc_sram_rd_streamer.sv
// tb/tb_pcieifc_sram_rd_streamer.sv - directed self-checking bench for pcieifc_sram_rd_streamer
module tb_pcieifc_sram_rd_streamer;
  localparam int DW    = 256;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcieifc_sram_rd_streamer_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

`ifdef PCIEI_RDSTRM_STAT_EN
  logic [15:0] stat_cmd_cnt;
  logic [31:0] stat_word_cnt;
`endif

  pcieifc_sram_rd_streamer #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PCIEI_RDSTRM_STAT_EN
    ,
    .stat_cmd_cnt(stat_cmd_cnt),
    .stat_word_cnt(stat_word_cnt)
`endif
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.sram_reb) bus.sram_doutb <= mem[bus.sram_addrb];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit a5_at_5 = 1'b1;
  int bp_seq[16] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1};

  int            iss_addr[$];
  int            iss_cyc[$];
  logic [DW-1:0] pop_data[$];
  logic          pop_last[$];
  int            pop_cyc[$];
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert (bus.out_valid === 1'b1 && bus.out_data === prev_data && bus.out_last === prev_last)
          else begin
            failures++;
            $error("FAIL stall_stable observed v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
          end
      end
      if (bus.sram_reb) begin
        iss_addr.push_back(int'(bus.sram_addrb));
        iss_cyc.push_back(cyc);
        outstanding++;
        checks++;
        assert (bus.cmd_ready === 1'b0)
          else begin failures++; $error("FAIL reb_in_idle observed=%0b expected=0", bus.cmd_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        pop_data.push_back(bus.out_data);
        pop_last.push_back(bus.out_last);
        pop_cyc.push_back(cyc);
        outstanding--;
      end
      checks++;
      assert (outstanding <= 2)
        else begin failures++; $error("FAIL outstanding observed=%0d expected<=2", outstanding); end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin failures++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

  function automatic logic [DW-1:0] exp_word(input int a);
    if (a5_at_5 && a == 5) return DW'(32'hA5);
    return DW'(a);
  endfunction

  task automatic clear_queues();
    iss_addr.delete(); iss_cyc.delete();
    pop_data.delete(); pop_last.delete(); pop_cyc.delete();
  endtask

  task automatic run_cmd(input int addr, input int len, input bit bp, output int c_acc, output int c_done);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = (AW + 1)'(len);
    bus.out_ready = bp ? (bp_seq[0] != 0) : 1'b1;
    #2;
    chk("cmd_accept", int'(bus.cmd_ready), 1);
    c_acc  = cyc;
    c_done = -1;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.out_ready = bp ? (bp_seq[i % 16] != 0) : 1'b1;
      #2;
      if (bus.cmd_ready) begin
        c_done = cyc;
        break;
      end
    end
    chk("cmd_done_in_budget", int'(c_done >= 0), 1);
  endtask

  task automatic check_stream(input int addr, input int len, input int c_acc, input int c_done, input bit full);
    chk("n_issue", iss_addr.size(), len);
    chk("n_pop", pop_data.size(), len);
    for (int k = 0; k < len; k++) begin
      if (k < iss_addr.size()) chk("iss_addr", iss_addr[k], (addr + k) % DEPTH);
      if (k < pop_data.size()) begin
        chk_data("pop_data", pop_data[k], exp_word((addr + k) % DEPTH));
        chk("pop_last", int'(pop_last[k]), int'(k == len - 1));
      end
    end
    if (full && len > 0 && iss_cyc.size() == len && pop_cyc.size() == len) begin
      chk("first_issue_lat", iss_cyc[0] - c_acc, 1);
      chk("last_issue_lat", iss_cyc[len-1] - c_acc, len);
      chk("first_pop_lat", pop_cyc[0] - c_acc, 3);
      chk("last_pop_lat", pop_cyc[len-1] - c_acc, len + 2);
      chk("done_lat", c_done - c_acc, len + 3);
    end
    clear_queues();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cd;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    mem[5] = DW'(32'hA5);

    repeat (3) @(negedge clk);
    #2;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
    chk("rst_reb", int'(bus.sram_reb), 0);
    chk("rst_addrb", int'(bus.sram_addrb), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk_data("rst_out_data", bus.out_data, '0);
    chk("rst_out_last", int'(bus.out_last), 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("idle_cmd_ready", int'(bus.cmd_ready), 1);

    run_cmd(5, 1, 1'b0, ca, cd);
    check_stream(5, 1, ca, cd, 1'b1);
    mem[5]  = DW'(5);
    a5_at_5 = 1'b0;

    run_cmd(0, 8, 1'b0, ca, cd);
    check_stream(0, 8, ca, cd, 1'b1);

    run_cmd(510, 4, 1'b0, ca, cd);
    check_stream(510, 4, ca, cd, 1'b1);

    run_cmd(20, 6, 1'b1, ca, cd);
    check_stream(20, 6, ca, cd, 1'b0);

    run_cmd(40, 0, 1'b0, ca, cd);
    chk("zero_len_done", cd - ca, 1);
    repeat (4) @(negedge clk);
    #2;
    check_stream(40, 0, ca, cd, 1'b0);

`ifdef PCIEI_RDSTRM_STAT_EN
    chk("stat_cmd_cnt", int'(stat_cmd_cnt), 4);
    chk("stat_word_cnt", int'(stat_word_cnt), 19);
`endif

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(100);
    bus.cmd_len   = (AW + 1)'(10);
    bus.out_ready = 1'b1;
    #2;
    chk("rst_cmd_accept", int'(bus.cmd_ready), 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #2;
      if (pop_data.size() >= 3) break;
    end
    chk("rst_reach_3_pops", pop_data.size(), 3);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_pulse_cmd_ready", int'(bus.cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("post_rst_reb", int'(bus.sram_reb), 0);
    chk("post_rst_addrb", int'(bus.sram_addrb), 0);
    chk("post_rst_out_valid", int'(bus.out_valid), 0);
    chk_data("post_rst_out_data", bus.out_data, '0);
    chk("post_rst_out_last", int'(bus.out_last), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("post_rst_quiet", int'(bus.out_valid), 0);
    end
    chk("rst_total_pops", pop_data.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < pop_data.size()) chk_data("rst_pop_data", pop_data[k], DW'(100 + k));
    end
    clear_queues();

    run_cmd(300, 2, 1'b0, ca, cd);
    check_stream(300, 2, ca, cd, 1'b1);

`ifdef PCIEI_RDSTRM_STAT_EN
    chk("stat_cmd_cnt_after_rst", int'(stat_cmd_cnt), 1);
    chk("stat_word_cnt_after_rst", int'(stat_word_cnt), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
